exe_stage: RTL
==============

Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
- Consumes the decode→execute bus and evaluates the ALU result.
- Issues the data-SRAM request for lw/sw.
- Owns the architectural HI/LO registers and an iterative 32-cycle divider for div/divu.
- Produces the execute→memory bus and the execute forwarding bus back to decode.

Parameters:
- DS_TO_ES_BUS_WD, 208, width of incoming decode bus
- ES_TO_MS_BUS_WD, 71, width of outgoing memory-stage bus
- FW_BUS_WD, 38, width of forwarding bus {gr_we, dest[4:0], value[31:0]}

Ports:
- clk  in  1  clock
- resetn  in  1  async active-low reset
- ms_allowin  in  1  memory stage can accept
- es_allowin  out  1  this stage can accept
- ds_to_es_valid  in  1  decode bus valid
- ds_to_es_bus  in  208  fields, msb first: mthi 207, mtlo 206, mfhi 205, mflo 204, mul_sel 203, div_sel[1:0] {div,divu} 202:201, hi 200:169, lo 168:137, zext_imm 136, alu_op[11:0] 135:124, load_op 123, src1_is_sa 122, src1_is_pc 121, src2_is_imm 120, src2_is_8 119, gr_we 118, mem_we 117, dest 116:112, imm 111:96, rs_value 95:64, rt_value 63:32, pc 31:0
- es_to_ms_valid  out  1  memory-stage bus valid
- es_to_ms_bus  out  71  {load_op 70, gr_we 69, dest 68:64, result 63:32, pc 31:0}
- es_to_ds_fw_bus  out  38  {gr_we & es_valid, dest, result}
- out_es_valid  out  1  es_valid register
- data_sram_en  out  1  request enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  address
- data_sram_wdata  out  32  store data

Behaviour:
- Reset (async, resetn=0): es_valid=0, HI=LO=0, divider state IDLE with counter=0. Every output derived from es_valid is 0, and data_sram_en=0.
- Handshake:
  - es_allowin = !es_valid | (es_ready_go & ms_allowin).
  - On es_allowin: es_valid <= ds_to_es_valid, and the bus register is captured when ds_to_es_valid=1.
  - es_to_ms_valid = es_valid & es_ready_go.
  - es_ready_go = 1, except for a valid div/divu until the divider reaches DONE.
- Operands:
  - src1 = src1_is_sa ? {27'b0, imm[10:6]} : src1_is_pc ? pc : rs_value.
  - src2 = src2_is_imm ? (zext_imm ? {16'b0, imm} : sign-ext imm) : src2_is_8 ? 32'd8 : rt_value.
  - These feed the existing alu module, which computes the one-hot alu_op function.
- Result mux: mfhi → HI, mflo → LO, otherwise alu_result.
- Memory request:
  - data_sram_en = es_valid & (load_op | mem_we) & ms_allowin.
  - data_sram_wen = {4{mem_we & es_valid}}.
  - addr = alu_result.
  - wdata = rt_value.
  - The request is issued in the cycle the instruction hands off.
- HI/LO update on handoff (es_valid & es_ready_go & ms_allowin):
  - mul_sel: HI <= bus hi, LO <= bus lo.
  - div/divu: LO <= quotient, HI <= remainder.
  - mthi: HI <= rs_value.
  - mtlo: LO <= rs_value.
  - An mfhi/mflo entering the next cycle reads the updated value.
- Divider FSM:
  - IDLE → RUN when es_valid & |div_sel: latch |rs|, |rt| (abs only for div), and the signs; counter=0.
  - RUN: one restoring shift-subtract step per cycle; counter 0..31; after step 31 → DONE.
  - DONE: es_ready_go=1, result held. On handoff → IDLE.
  - Latency: the div occupies EX for 34 cycles (1 IDLE capture + 32 RUN + 1 DONE).
  - Signed fixup: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide-by-zero (deterministic): unsigned q=0xFFFFFFFF, r=dividend; the signed case applies the same fixup to those magnitudes.
- DONE held while ms_allowin=0: result and HI/LO are not yet written; they are written exactly once, at handoff.
- Reset mid-RUN: FSM → IDLE, es_valid=0, HI/LO unchanged from their reset value of 0.
- Forward bus: gr_we bit masked by es_valid. Decode uses es_to_ms_bus[70] (load) to stall, so load_op must be valid whenever es_valid=1.

Test Plan:
- addiu rs=5, imm=0xFFFF → result 4, gr_we=1, es_to_ms_valid on the next cycle after capture; fw bus carries {1, dest, 4}.
- sw rs=0x1000, imm=8, rt=0xDEADBEEF → data_sram_en=1, wen=4'hF, addr 0x1008, wdata 0xDEADBEEF; with ms_allowin=0 → en=0, instruction held.
- div rs=-7 (0xFFFFFFF9), rt=2 → es_allowin=0 for 33 cycles, handoff on the 34th; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); a following mflo yields 0xFFFFFFFD.
- divu rs=100, rt=0 → LO=0xFFFFFFFF, HI=100.
- mult bus hi=0x1, lo=0x2, then mfhi, then mtlo rs=0x55, then mflo → results 0x1 and 0x55.
- Assert resetn=0 at RUN counter=10 → es_valid=0, es_to_ms_valid=0 immediately; after release, a new addu completes normally with HI=LO=0.

Source files
------------

// File: rtl/exe_stage_if.sv
// Execute-stage bundle: decode->execute input bus, execute->memory output bus,
// decode forwarding path and the data-SRAM request.
interface exe_stage_if #(
  parameter int unsigned DS_TO_ES_BUS_WD = 208,
  parameter int unsigned ES_TO_MS_BUS_WD = 71,
  parameter int unsigned FW_BUS_WD       = 38
);
  logic                       ms_allowin;
  logic                       es_allowin;
  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [FW_BUS_WD-1:0]       es_to_ds_fw_bus;
  logic                       out_es_valid;
  logic                       data_sram_en;
  logic [3:0]                 data_sram_wen;
  logic [31:0]                data_sram_addr;
  logic [31:0]                data_sram_wdata;

  // master: the execute stage itself; slave: its surroundings.
  modport master (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_fw_bus, out_es_valid,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_fw_bus, out_es_valid,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, data-SRAM request, HI/LO registers and a 32-step
// restoring divider for div/divu.
module exe_stage #(
  parameter int unsigned DS_TO_ES_BUS_WD = 208,
  parameter int unsigned ES_TO_MS_BUS_WD = 71,
  parameter int unsigned FW_BUS_WD       = 38
) (
  input logic         clk,
  input logic         resetn,
  exe_stage_if.master es
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} div_state_e;

  logic                       es_valid_q;
  logic [DS_TO_ES_BUS_WD-1:0] bus_q;
  logic [31:0]                hi_q, lo_q;
  div_state_e                 div_state_q, div_state_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic [31:0]                rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic                       neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic        mthi, mtlo, mfhi, mflo, mul_sel, zext_imm, load_op;
  logic        src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we;
  logic [1:0]  div_sel;
  logic [31:0] bus_hi, bus_lo, rs_value, rt_value, pc;
  logic [11:0] alu_op;
  logic [4:0]  dest;
  logic [15:0] imm;

  assign {mthi, mtlo, mfhi, mflo, mul_sel, div_sel, bus_hi, bus_lo, zext_imm, alu_op, load_op,
          src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we, dest, imm,
          rs_value, rt_value, pc} = bus_q;

  logic is_div, es_ready_go, es_handoff;
  assign is_div      = es_valid_q & (|div_sel);
  assign es_ready_go = !is_div || (div_state_q == StDone);
  assign es_handoff  = es_valid_q & es_ready_go & es.ms_allowin;
  assign es.es_allowin = !es_valid_q || (es_ready_go && es.ms_allowin);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      bus_q      <= '0;
    end else if (es.es_allowin) begin
      es_valid_q <= es.ds_to_es_valid;
      if (es.ds_to_es_valid) bus_q <= es.ds_to_es_bus;
    end
  end

  // ALU; one-hot op order: add sub slt sltu and nor or xor sll srl sra lui.
  logic [31:0] src1, src2, add_res, sub_res, alu_result, result;
  logic        slt_res, sltu_res;

  assign src1 = src1_is_sa ? {27'b0, imm[10:6]} : src1_is_pc ? pc : rs_value;
  assign src2 = src2_is_imm ? (zext_imm ? {16'b0, imm} : {{16{imm[15]}}, imm})
              : src2_is_8   ? 32'd8 : rt_value;
  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = (src1[31] & ~src2[31]) | (~(src1[31] ^ src2[31]) & sub_res[31]);
  assign sltu_res = src1 < src2;

  always_comb begin
    alu_result = '0;
    if (alu_op[0])  alu_result = alu_result | add_res;
    if (alu_op[1])  alu_result = alu_result | sub_res;
    if (alu_op[2])  alu_result = alu_result | {31'b0, slt_res};
    if (alu_op[3])  alu_result = alu_result | {31'b0, sltu_res};
    if (alu_op[4])  alu_result = alu_result | (src1 & src2);
    if (alu_op[5])  alu_result = alu_result | ~(src1 | src2);
    if (alu_op[6])  alu_result = alu_result | (src1 | src2);
    if (alu_op[7])  alu_result = alu_result | (src1 ^ src2);
    if (alu_op[8])  alu_result = alu_result | (src2 << src1[4:0]);
    if (alu_op[9])  alu_result = alu_result | (src2 >> src1[4:0]);
    if (alu_op[10]) alu_result = alu_result | 32'($signed(src2) >>> src1[4:0]);
    if (alu_op[11]) alu_result = alu_result | {src2[15:0], 16'b0};
  end

  assign result = mfhi ? hi_q : mflo ? lo_q : alu_result;

  // Divider: magnitudes are divided unsigned, signs fixed up on the way out.
  logic        div_signed;
  logic [32:0] shifted, trial;
  assign div_signed = div_sel[1];
  assign shifted    = {rem_q, quo_q[31]};
  assign trial      = shifted - {1'b0, dvs_q};

  always_comb begin
    div_state_d = div_state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    unique case (div_state_q)
      StIdle: if (is_div) begin
        div_state_d = StRun;
        cnt_d       = 5'd0;
        rem_d       = '0;
        quo_d       = (div_signed && rs_value[31]) ? -rs_value : rs_value;
        dvs_d       = (div_signed && rt_value[31]) ? -rt_value : rt_value;
        neg_quo_d   = div_signed & (rs_value[31] ^ rt_value[31]);
        neg_rem_d   = div_signed & rs_value[31];
      end
      StRun: begin
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) div_state_d = StDone;
      end
      StDone: if (es_handoff) div_state_d = StIdle;
      default: div_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_state_q <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (es_handoff) begin
      if (mul_sel) begin
        hi_q <= bus_hi;
        lo_q <= bus_lo;
      end else if (|div_sel) begin
        lo_q <= neg_quo_q ? -quo_q : quo_q;
        hi_q <= neg_rem_q ? -rem_q : rem_q;
      end else begin
        if (mthi) hi_q <= rs_value;
        if (mtlo) lo_q <= rs_value;
      end
    end
  end

  assign es.es_to_ms_valid  = es_valid_q & es_ready_go;
  assign es.es_to_ms_bus    = {load_op, gr_we, dest, result, pc};
  assign es.es_to_ds_fw_bus = {gr_we & es_valid_q, dest, result};
  assign es.out_es_valid    = es_valid_q;
  assign es.data_sram_en    = es_valid_q & (load_op | mem_we) & es.ms_allowin;
  assign es.data_sram_wen   = {4{mem_we & es_valid_q}};
  assign es.data_sram_addr  = alu_result;
  assign es.data_sram_wdata = rt_value;

endmodule
